// File: rtl/fpu_issue_ctrl.sv
// Sequences one multi-cycle FPU op at a time: holds operands, counts
// latency, captures the result and strobes a single-cycle writeback.
module fpu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [4:0]        issue_cont,
    input  logic [CNT_W-1:0]  issue_lat,
    input  logic [DATA_W-1:0] issue_x1,
    input  logic [DATA_W-1:0] issue_x2,
    input  logic [4:0]        issue_rd,
    input  logic              issue_rd_float,
    input  logic              flush,
    output logic              issue_ready,
    output logic              stall_req,
    output logic [DATA_W-1:0] fpu_x1,
    output logic [DATA_W-1:0] fpu_x2,
    output logic [4:0]        fpu_cont,
    input  logic [DATA_W-1:0] fpu_y,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_rd_float,
    output logic              pend_valid,
    output logic [4:0]        pend_rd,
    output logic              pend_rd_float,
    output logic [PERF_W-1:0] busy_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   x1_q, x2_q;
    logic [4:0]          cont_q;
    logic [4:0]          rd_q;
    logic                rdf_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic [4:0]          wb_rd_q;
    logic                wb_rdf_q;
    logic                wb_valid_q;
    logic                pend_valid_q;
    logic [PERF_W-1:0]   busy_q;
    logic                accept;
    logic                capture;

    assign issue_ready = (state_q == IDLE) | (state_q == WB);
    assign accept      = issue_valid & issue_ready & ~flush;
    // A flush kills the op before its result is taken.
    assign capture     = (state_q == EXEC) & ~flush & (cnt_q == '0);
    assign stall_req   = (issue_valid & ~issue_ready) | (state_q == EXEC);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    if (flush) state_d = IDLE;
                     else if (cnt_q == '0) state_d = WB;
            WB:      state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            cont_q       <= '0;
            rd_q         <= '0;
            rdf_q        <= 1'b0;
            wb_data_q    <= '0;
            wb_rd_q      <= '0;
            wb_rdf_q     <= 1'b0;
            wb_valid_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            busy_q       <= '0;
        end else begin
            state_q      <= state_d;
            wb_valid_q   <= (state_d == WB);
            pend_valid_q <= (state_d == EXEC);
            if (accept) begin
                x1_q   <= issue_x1;
                x2_q   <= issue_x2;
                cont_q <= issue_cont;
                rd_q   <= issue_rd;
                rdf_q  <= issue_rd_float;
                cnt_q  <= issue_lat;
            end else if (state_q == EXEC && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (capture) begin
                wb_data_q <= fpu_y;
                wb_rd_q   <= rd_q;
                wb_rdf_q  <= rdf_q;
            end
            if (state_q == EXEC && busy_q != '1) begin
                busy_q <= busy_q + 1'b1;
            end
        end
    end

    assign fpu_x1        = x1_q;
    assign fpu_x2        = x2_q;
    assign fpu_cont      = cont_q;
    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = wb_rd_q;
    assign wb_rd_float   = wb_rdf_q;
    assign pend_valid    = pend_valid_q;
    assign pend_rd       = rd_q;
    assign pend_rd_float = rdf_q;
    assign busy_cycles   = busy_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: vector table of ops plus hand-written
// back-to-back, flush, async reset and counter saturation sequences.
module tb_fpu_issue_ctrl;

    logic        clk, rst;
    logic        issue_valid, issue_rd_float, flush;
    logic [4:0]  issue_cont, issue_rd;
    logic [3:0]  issue_lat;
    logic [31:0] issue_x1, issue_x2;

    logic        issue_ready, stall_req, wb_valid, wb_rd_float;
    logic        pend_valid, pend_rd_float;
    logic [31:0] fpu_x1, fpu_x2, fpu_y, wb_data, busy_cycles;
    logic [4:0]  fpu_cont, wb_rd, pend_rd;

    logic        issue_ready4, stall_req4, wb_valid4, wb_rd_float4;
    logic        pend_valid4, pend_rd_float4;
    logic [31:0] fpu_x1_4, fpu_x2_4, fpu_y4, wb_data4;
    logic [3:0]  busy4;
    logic [4:0]  fpu_cont4, wb_rd4, pend_rd4;

    int n_err = 0;
    int n_chk = 0;

    // Stand-in fpu: fadd(1.0,2.0)=3.0, other fpu ops a fixed mix, non-fpu ops 0.
    function automatic logic [31:0] fmodel(logic [31:0] a, logic [31:0] b,
                                           logic [4:0] c);
        if (c[4] == 1'b0) return 32'h0;
        if (c == 5'b10000 && a == 32'h3F800000 && b == 32'h40000000)
            return 32'h40400000;
        return a ^ {b[15:0], b[31:16]} ^ {27'b0, c};
    endfunction

    assign fpu_y  = fmodel(fpu_x1, fpu_x2, fpu_cont);
    assign fpu_y4 = fmodel(fpu_x1_4, fpu_x2_4, fpu_cont4);

    fpu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_cont(issue_cont),
        .issue_lat(issue_lat), .issue_x1(issue_x1), .issue_x2(issue_x2),
        .issue_rd(issue_rd), .issue_rd_float(issue_rd_float),
        .flush(flush), .issue_ready(issue_ready), .stall_req(stall_req),
        .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_cont(fpu_cont),
        .fpu_y(fpu_y), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_rd_float(wb_rd_float),
        .pend_valid(pend_valid), .pend_rd(pend_rd),
        .pend_rd_float(pend_rd_float), .busy_cycles(busy_cycles)
    );

    fpu_issue_ctrl #(.PERF_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_cont(issue_cont),
        .issue_lat(issue_lat), .issue_x1(issue_x1), .issue_x2(issue_x2),
        .issue_rd(issue_rd), .issue_rd_float(issue_rd_float),
        .flush(flush), .issue_ready(issue_ready4), .stall_req(stall_req4),
        .fpu_x1(fpu_x1_4), .fpu_x2(fpu_x2_4), .fpu_cont(fpu_cont4),
        .fpu_y(fpu_y4), .wb_valid(wb_valid4), .wb_data(wb_data4),
        .wb_rd(wb_rd4), .wb_rd_float(wb_rd_float4),
        .pend_valid(pend_valid4), .pend_rd(pend_rd4),
        .pend_rd_float(pend_rd_float4), .busy_cycles(busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] x1;
        logic [31:0] x2;
        logic [4:0]  cont;
        logic [3:0]  lat;
        logic [4:0]  rd;
        logic        rdf;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        issue_x1       = v.x1;
        issue_x2       = v.x2;
        issue_cont     = v.cont;
        issue_lat      = v.lat;
        issue_rd       = v.rd;
        issue_rd_float = v.rdf;
    endtask

    // Issue one op from IDLE; if hold, keep issue_valid up with other operands.
    task automatic run_op(input vec_t v, input bit hold);
        drive(v);
        issue_valid = 1'b1;
        #1;
        chk("accept_ready", {31'b0, issue_ready}, 32'd1);
        chk("accept_stall", {31'b0, stall_req}, 32'd0);
        step();
        if (hold) begin
            issue_x1   = ~v.x1;
            issue_x2   = ~v.x2;
            issue_cont = 5'b10001;
        end else begin
            issue_valid = 1'b0;
        end
        for (int k = 0; k <= int'(v.lat); k++) begin
            #1;
            chk("exec_pend", {31'b0, pend_valid}, 32'd1);
            chk("exec_stall", {31'b0, stall_req}, 32'd1);
            chk("exec_wbv", {31'b0, wb_valid}, 32'd0);
            chk("exec_x1", fpu_x1, v.x1);
            chk("exec_x2", fpu_x2, v.x2);
            chk("exec_prd", {27'b0, pend_rd}, {27'b0, v.rd});
            if (hold) chk("exec_ready", {31'b0, issue_ready}, 32'd0);
            if (k == int'(v.lat)) issue_valid = 1'b0;
            step();
        end
        #1;
        chk("wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("wb_data", wb_data, v.exp);
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, v.rd});
        chk("wb_rdf", {31'b0, wb_rd_float}, {31'b0, v.rdf});
        chk("wb_stall", {31'b0, stall_req}, 32'd0);
        chk("wb4_data", wb_data4, v.exp);
        step();
        #1;
        chk("post_wbv", {31'b0, wb_valid}, 32'd0);
        chk("post_pend", {31'b0, pend_valid}, 32'd0);
    endtask

    initial begin
        tv[0] = '{32'h3F800000, 32'h40000000, 5'b10000, 4'd4, 5'd5, 1'b1,
                  32'h40400000};
        tv[1] = '{32'hC0000000, 32'h3F800000, 5'b10100, 4'd0, 5'd7, 1'b1, 0};
        tv[2] = '{32'h12345678, 32'h9ABCDEF0, 5'b10010, 4'd3, 5'd31, 1'b0, 0};
        tv[3] = '{32'hDEADBEEF, 32'h0BADF00D, 5'b00111, 4'd1, 5'd1, 1'b0, 0};
        tv[4] = '{32'hA5A5A5A5, 32'h5A5A0F0F, 5'b11101, 4'd15, 5'd0, 1'b1, 0};
        tv[5] = '{32'h40800000, 32'h40000000, 5'b10011, 4'd6, 5'd12, 1'b1, 0};
        for (int i = 1; i < 6; i++)
            tv[i].exp = fmodel(tv[i].x1, tv[i].x2, tv[i].cont);

        rst = 1'b1;
        flush = 1'b0;
        issue_valid = 1'b0;
        drive(tv[0]);
        step();
        step();
        #1;
        chk("rst_pend", {31'b0, pend_valid}, 32'd0);
        chk("rst_wbv", {31'b0, wb_valid}, 32'd0);
        chk("rst_ready", {31'b0, issue_ready}, 32'd1);
        chk("rst_cont", {27'b0, fpu_cont}, 32'd0);
        chk("rst_x1", fpu_x1, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_busy", busy_cycles, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_op(tv[i], i == 0);
        chk("busy_table", busy_cycles, 32'd28);
        chk("busy4_table", {28'b0, busy4}, 32'hF);

        // Back-to-back: second op accepted in the WB cycle of the first.
        drive(tv[1]);
        issue_valid = 1'b1;
        step();
        drive(tv[2]);
        #1;
        chk("b2b_exec_ready", {31'b0, issue_ready}, 32'd0);
        chk("b2b_exec_stall", {31'b0, stall_req}, 32'd1);
        chk("b2b_exec_x1", fpu_x1, tv[1].x1);
        step();
        #1;
        chk("b2b_wbA_valid", {31'b0, wb_valid}, 32'd1);
        chk("b2b_wbA_data", wb_data, tv[1].exp);
        chk("b2b_wbA_ready", {31'b0, issue_ready}, 32'd1);
        chk("b2b_wbA_stall", {31'b0, stall_req}, 32'd0);
        step();
        issue_valid = 1'b0;
        for (int k = 0; k <= int'(tv[2].lat); k++) begin
            #1;
            chk("b2b_execB_wbv", {31'b0, wb_valid}, 32'd0);
            chk("b2b_execB_x1", fpu_x1, tv[2].x1);
            step();
        end
        #1;
        chk("b2b_wbB_valid", {31'b0, wb_valid}, 32'd1);
        chk("b2b_wbB_data", wb_data, tv[2].exp);
        chk("b2b_wbB_rd", {27'b0, wb_rd}, {27'b0, tv[2].rd});
        step();

        // Flush in the third EXEC cycle of a lat=6 op.
        drive(tv[5]);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        step();
        step();
        flush = 1'b1;
        #1;
        chk("fl_pend", {31'b0, pend_valid}, 32'd1);
        step();
        flush = 1'b0;
        #1;
        chk("fl_pend_after", {31'b0, pend_valid}, 32'd0);
        chk("fl_ready_after", {31'b0, issue_ready}, 32'd1);
        chk("fl_stall_after", {31'b0, stall_req}, 32'd0);
        chk("fl_hold_x1", fpu_x1, tv[5].x1);
        for (int k = 0; k < 8; k++) begin
            step();
            #1;
            chk("fl_no_wb", {31'b0, wb_valid}, 32'd0);
        end

        // issue_valid alongside flush in IDLE is not accepted.
        drive(tv[1]);
        issue_valid = 1'b1;
        flush = 1'b1;
        step();
        issue_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("fl_idle_noacc", {31'b0, pend_valid}, 32'd0);
        step();
        #1;
        chk("fl_idle_nowb", {31'b0, wb_valid}, 32'd0);

        // Flush during WB does not suppress the writeback strobe.
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        step();
        flush = 1'b1;
        #1;
        chk("fl_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("fl_wb_data", wb_data, tv[1].exp);
        step();
        flush = 1'b0;
        #1;
        chk("fl_wb_idle", {31'b0, pend_valid}, 32'd0);

        // Asynchronous reset in the middle of an EXEC cycle.
        drive(tv[5]);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pend", {31'b0, pend_valid}, 32'd0);
        chk("arst_stall", {31'b0, stall_req}, 32'd0);
        chk("arst_wbv", {31'b0, wb_valid}, 32'd0);
        chk("arst_busy", busy_cycles, 32'd0);
        chk("arst_busy4", {28'b0, busy4}, 32'd0);
        chk("arst_cont", {27'b0, fpu_cont}, 32'd0);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step();
            #1;
            chk("arst_no_wb", {31'b0, wb_valid}, 32'd0);
        end

        // Three lat=6 ops: 21 EXEC cycles, 4-bit counter sticks at 4'hF.
        run_op(tv[5], 1'b0);
        chk("sat_busy4_1", {28'b0, busy4}, 32'd7);
        run_op(tv[5], 1'b0);
        run_op(tv[5], 1'b0);
        chk("sat_busy", busy_cycles, 32'd21);
        chk("sat_busy4", {28'b0, busy4}, 32'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
